// File: rtl/upset_event_logger.sv
// Upset event logger: registers sensor-tree error lines, counts rising edges per channel
// and queues timestamped {channel, ts} records for valid/ready readout.
module upset_event_logger #(
  parameter int CHANNELS   = 4,
  parameter int COUNT_W    = 16,
  parameter int TS_W       = 32,
  parameter int FIFO_DEPTH = 8,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHANNELS-1:0]         sensor_error,
  input  logic                        clear,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [CH_W-1:0]             evt_channel,
  output logic [TS_W-1:0]             evt_timestamp,
  output logic [CHANNELS*COUNT_W-1:0] count,
  output logic                        overflow,
  output logic                        any_error
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [CHANNELS-1:0] s1_reg;
  logic [CHANNELS-1:0] s2_reg;
  logic [CHANNELS-1:0] rise;
  logic [TS_W-1:0]     ts_reg;

  logic [CHANNELS-1:0] pend_reg;
  logic [CHANNELS-1:0] pend_next;
  logic [TS_W-1:0]     pend_ts_reg [CHANNELS];
  logic [CHANNELS-1:0] grant;
  logic [CHANNELS-1:0] take;
  logic [CHANNELS-1:0] coalesce;
  logic [CH_W-1:0]     grant_idx;
  logic                grant_found;
  logic                overflow_reg;

  logic [CH_W-1:0]     fifo_ch_mem [FIFO_DEPTH];
  logic [TS_W-1:0]     fifo_ts_mem [FIFO_DEPTH];
  logic [PTR_W:0]      wr_ptr_reg;
  logic [PTR_W:0]      rd_ptr_reg;
  logic                fifo_empty;
  logic                fifo_full;
  logic                push;
  logic                pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg <= '0;
      s2_reg <= '0;
      ts_reg <= '0;
    end else begin
      s1_reg <= sensor_error;
      s2_reg <= s1_reg;
      ts_reg <= ts_reg + TS_W'(1);
    end
  end

  assign rise      = s1_reg & ~s2_reg;
  assign any_error = |s1_reg;

  // Per-channel saturating counters; clear wins over a same-cycle rise.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_cnt
      logic [COUNT_W-1:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (rst || clear) begin
          cnt_reg <= '0;
        end else if (rise[gi] && (cnt_reg != '1)) begin
          cnt_reg <= cnt_reg + COUNT_W'(1);
        end
      end
      assign count[gi*COUNT_W +: COUNT_W] = cnt_reg;
    end
  endgenerate

  // Fixed-priority arbiter: lowest-index pending channel goes to the queue.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (pend_reg[i] && !grant_found) begin
        grant_found = 1'b1;
        grant[i]    = 1'b1;
        grant_idx   = CH_W'(i);
      end
    end
  end

  assign pop       = ~fifo_empty & evt_ready;
  assign push      = grant_found & (~fifo_full | pop);
  assign take      = push ? grant : '0;
  // A rise on a channel being pushed this cycle starts a fresh pending record.
  assign pend_next = (pend_reg & ~take) | rise;
  assign coalesce  = rise & pend_reg & ~take;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg <= '0;
    end else begin
      pend_reg <= pend_next;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (rise[i] && (!pend_reg[i] || take[i])) begin
        pend_ts_reg[i] <= ts_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      overflow_reg <= 1'b0;
    end else if (|coalesce) begin
      overflow_reg <= 1'b1;
    end
  end

  assign overflow = overflow_reg;

  // Record storage carries no reset; the read side is masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_ch_mem[wr_ptr_reg[PTR_W-1:0]] <= grant_idx;
      fifo_ts_mem[wr_ptr_reg[PTR_W-1:0]] <= pend_ts_reg[grant_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + (PTR_W+1)'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + (PTR_W+1)'(1);
      end
    end
  end

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                      (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);

  assign evt_valid     = ~fifo_empty;
  assign evt_channel   = fifo_empty ? '0 : fifo_ch_mem[rd_ptr_reg[PTR_W-1:0]];
  assign evt_timestamp = fifo_empty ? '0 : fifo_ts_mem[rd_ptr_reg[PTR_W-1:0]];

endmodule

// File: tb/tb_upset_event_logger.sv
// Directed bench for upset_event_logger: cycle table plus hand-written sequences
// for queue fill/drain, saturation, clear, reset and timestamp wrap.
module tb_upset_event_logger;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  se = 4'b0000;
  logic        clear = 1'b0;
  logic        evt_ready = 1'b0;
  logic        evt_valid;
  logic [1:0]  evt_channel;
  logic [7:0]  evt_timestamp;
  logic [15:0] count;
  logic        overflow;
  logic        any_error;

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] tb_ts;

  typedef struct {
    logic [3:0]  se;
    logic        clr;
    logic        rdy;
    int          n;
    logic        ev;
    logic [1:0]  ch;
    logic [7:0]  ts;
    logic [15:0] cnt;
    logic        ov;
    logic        ae;
  } vec_t;

  typedef struct {
    logic [1:0] ch;
    logic [7:0] ts;
  } rec_t;

  vec_t tbl [15];
  rec_t exp_q [$];

  upset_event_logger #(
    .CHANNELS  (4),
    .COUNT_W   (4),
    .TS_W      (8),
    .FIFO_DEPTH(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sensor_error (se),
    .clear        (clear),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_channel  (evt_channel),
    .evt_timestamp(evt_timestamp),
    .count        (count),
    .overflow     (overflow),
    .any_error    (any_error)
  );

  always #5 clk = ~clk;

  // Reference timestamp: cycles since reset release, 8-bit wrap.
  always @(posedge clk) begin
    if (rst) tb_ts <= 8'd0;
    else     tb_ts <= tb_ts + 8'd1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One-cycle high pulse; returns the ts of the rise cycle.
  task automatic pulse(input int ch, output logic [7:0] ts_o);
    se[ch] = 1'b1;
    @(negedge clk);
    ts_o = tb_ts;
    se[ch] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    rec_t r;
    evt_ready = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (evt_valid) begin
        if (exp_q.size() == 0) begin
          check("extra record", 64'(evt_channel), 64'hFF);
        end else begin
          r = exp_q.pop_front();
          $display("record: ch=%0d ts=%0d (expect ch=%0d ts=%0d)", evt_channel, evt_timestamp, r.ch, r.ts);
          check("record ch", 64'(evt_channel), 64'(r.ch));
          check("record ts", 64'(evt_timestamp), 64'(r.ts));
        end
      end
      @(negedge clk);
    end
    check("records left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [7:0] t;
    logic [7:0] pts [4];
    int seq [10];
    bit found;

    // {se, clr, rdy, cycles | valid, ch, ts, count, overflow, any_error}
    tbl[0]  = '{4'b0000, 1'b0, 1'b0, 9, 1'b0, 2'd0, 8'd0,  16'h0000, 1'b0, 1'b0};
    tbl[1]  = '{4'b0100, 1'b0, 1'b0, 1, 1'b0, 2'd0, 8'd0,  16'h0000, 1'b0, 1'b1};
    tbl[2]  = '{4'b0100, 1'b0, 1'b0, 1, 1'b0, 2'd0, 8'd0,  16'h0100, 1'b0, 1'b1};
    tbl[3]  = '{4'b0000, 1'b0, 1'b0, 1, 1'b1, 2'd2, 8'd10, 16'h0100, 1'b0, 1'b0};
    tbl[4]  = '{4'b0000, 1'b0, 1'b0, 2, 1'b1, 2'd2, 8'd10, 16'h0100, 1'b0, 1'b0};
    tbl[5]  = '{4'b0000, 1'b0, 1'b1, 1, 1'b0, 2'd0, 8'd0,  16'h0100, 1'b0, 1'b0};
    tbl[6]  = '{4'b1001, 1'b0, 1'b1, 1, 1'b0, 2'd0, 8'd0,  16'h0100, 1'b0, 1'b1};
    tbl[7]  = '{4'b0000, 1'b0, 1'b1, 1, 1'b0, 2'd0, 8'd0,  16'h1101, 1'b0, 1'b0};
    tbl[8]  = '{4'b0000, 1'b0, 1'b1, 1, 1'b1, 2'd0, 8'd16, 16'h1101, 1'b0, 1'b0};
    tbl[9]  = '{4'b0000, 1'b0, 1'b1, 1, 1'b1, 2'd3, 8'd16, 16'h1101, 1'b0, 1'b0};
    tbl[10] = '{4'b0000, 1'b0, 1'b1, 1, 1'b0, 2'd0, 8'd0,  16'h1101, 1'b0, 1'b0};
    tbl[11] = '{4'b0001, 1'b0, 1'b0, 1, 1'b0, 2'd0, 8'd0,  16'h1101, 1'b0, 1'b1};
    tbl[12] = '{4'b0000, 1'b1, 1'b0, 1, 1'b0, 2'd0, 8'd0,  16'h0000, 1'b0, 1'b0};
    tbl[13] = '{4'b0000, 1'b0, 1'b0, 1, 1'b1, 2'd0, 8'd21, 16'h0000, 1'b0, 1'b0};
    tbl[14] = '{4'b0000, 1'b0, 1'b1, 1, 1'b0, 2'd0, 8'd0,  16'h0000, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset evt_valid", 64'(evt_valid), 64'd0);
    check("reset evt_channel", 64'(evt_channel), 64'd0);
    check("reset evt_timestamp", 64'(evt_timestamp), 64'd0);
    check("reset count", 64'(count), 64'd0);
    check("reset overflow", 64'(overflow), 64'd0);
    check("reset any_error", 64'(any_error), 64'd0);
    rst = 1'b0;

    // Cycle table: single upset at ts=10, simultaneous ch0/ch3, clear with rise
    for (int i = 0; i < 15; i++) begin
      se        = tbl[i].se;
      clear     = tbl[i].clr;
      evt_ready = tbl[i].rdy;
      repeat (tbl[i].n) @(negedge clk);
      $display("row %0d: valid=%0b ch=%0d ts=%0d count=%h ovf=%0b any=%0b",
               i, evt_valid, evt_channel, evt_timestamp, count, overflow, any_error);
      check($sformatf("row%0d valid", i), 64'(evt_valid), 64'(tbl[i].ev));
      check($sformatf("row%0d channel", i), 64'(evt_channel), 64'(tbl[i].ch));
      check($sformatf("row%0d timestamp", i), 64'(evt_timestamp), 64'(tbl[i].ts));
      check($sformatf("row%0d count", i), 64'(count), 64'(tbl[i].cnt));
      check($sformatf("row%0d overflow", i), 64'(overflow), 64'(tbl[i].ov));
      check($sformatf("row%0d any_error", i), 64'(any_error), 64'(tbl[i].ae));
    end
    se = 4'b0000;
    clear = 1'b0;

    // Fill: 10 upsets with consumer stalled, then ch1 pulses twice while pending
    evt_ready = 1'b0;
    seq = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2};
    for (int i = 0; i < 10; i++) begin
      pulse(seq[i], t);
      if (i < 8) exp_q.push_back('{2'(seq[i]), t});
      else       pts[seq[i]] = t;
    end
    pulse(1, t);
    pts[1] = t;
    pulse(1, t);
    check("fill evt_valid", 64'(evt_valid), 64'd1);
    check("fill overflow", 64'(overflow), 64'd1);
    check("fill count", 64'(count), 64'h2343);
    exp_q.push_back('{2'd0, pts[0]});
    exp_q.push_back('{2'd1, pts[1]});
    exp_q.push_back('{2'd2, pts[2]});
    drain(20);

    // Saturation: 20 pulses on ch0 with a 4-bit counter
    for (int i = 0; i < 20; i++) pulse(0, t);
    repeat (3) @(negedge clk);
    check("saturated count", 64'(count), 64'h234F);
    check("overflow sticky", 64'(overflow), 64'd1);
    check("saturation drained", 64'(evt_valid), 64'd0);

    // Clear in the same cycle as a ch0 rise
    se[0] = 1'b1;
    @(negedge clk);
    t = tb_ts;
    se[0] = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear count", 64'(count), 64'h0000);
    check("clear overflow", 64'(overflow), 64'd0);
    found = 1'b0;
    for (int c = 0; c < 6 && !found; c++) begin
      @(negedge clk);
      if (evt_valid) begin
        found = 1'b1;
        check("clear event ch", 64'(evt_channel), 64'd0);
        check("clear event ts", 64'(evt_timestamp), 64'(t));
      end
    end
    check("clear event seen", 64'(found), 64'd1);
    repeat (2) @(negedge clk);

    // Reset mid-operation with ch1 held high; queued records are discarded
    evt_ready = 1'b0;
    pulse(2, t);
    pulse(3, t);
    check("pre-reset queued", 64'(evt_valid), 64'd1);
    se[1] = 1'b1;
    do_reset();
    repeat (5) @(negedge clk);
    check("post-reset valid", 64'(evt_valid), 64'd1);
    check("post-reset ch", 64'(evt_channel), 64'd1);
    check("post-reset ts", 64'(evt_timestamp), 64'd1);
    check("post-reset count", 64'(count), 64'h0010);
    check("post-reset overflow", 64'(overflow), 64'd0);
    check("post-reset any_error", 64'(any_error), 64'd1);
    exp_q.push_back('{2'd1, 8'd1});
    drain(8);
    se = 4'b0000;

    // Timestamp wrap at TS_W=8
    evt_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 300 && tb_ts != 8'd254; c++) @(negedge clk);
    pulse(3, t);
    pulse(2, t);
    check("wrap count", 64'(count), 64'h1100);
    check("wrap overflow", 64'(overflow), 64'd0);
    check("wrap any_error", 64'(any_error), 64'd0);
    exp_q.push_back('{2'd3, 8'd255});
    exp_q.push_back('{2'd2, 8'd2});
    drain(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/upset_event_logger.md
# upset_event_logger

Sits directly downstream of the bit-flip `sensor` trees and turns their `error` levels into a record of upsets. It registers one error line per sensor tree and detects rising edges. For each edge it keeps a saturating per-channel upset count and queues a timestamped event record for readout over a valid/ready interface. It is the first stage that converts raw sensor state into data the monitor can report.

## Interface
- `CHANNELS`, 4: number of sensor trees watched; 1..16.
- `COUNT_W`, 16: width of each per-channel upset counter.
- `TS_W`, 32: width of the free-running timestamp.
- `FIFO_DEPTH`, 8: event queue depth; power of two, ≥2.
- `clk`  in  1  sole clock; every register is on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `sensor_error`  in  CHANNELS  `error` outputs of the sensor trees, one bit per channel, synchronous to `clk`.
- `clear`  in  1  one-cycle pulse; zeroes all counters and `overflow`.
- `evt_valid`  out  1  head of the event queue is valid.
- `evt_ready`  in  1  consumer accepts the head record when `evt_valid & evt_ready`.
- `evt_channel`  out  max(1,$clog2(CHANNELS))  channel index of the head record.
- `evt_timestamp`  out  TS_W  timestamp of the head record.
- `count`  out  CHANNELS*COUNT_W  per-channel upset counts; channel i occupies bits [i*COUNT_W +: COUNT_W].
- `overflow`  out  1  sticky; set when an event is coalesced, i.e. lost as a separate record.
- `any_error`  out  1  OR of the registered error lines.

## Operation
- Input stage: `s1 <= sensor_error`, `s2 <= s1`. `rise[i] = s1[i] & ~s2[i]`.
- Timestamp: `ts` is 0 after reset and increments every cycle. It wraps from all-ones to 0 and is never cleared by `clear`.
- Counters: on `rise[i]`, `count[i]` increments. It saturates at all-ones with no wrap.
- Pending: on `rise[i]`:
  - if `pend[i]` is 0, set it and latch `pend_ts[i] = ts`, the `ts` value in the same cycle as `rise[i]`;
  - if `pend[i]` is already 1, the count still increments, `pend_ts[i]` is unchanged, and `overflow` is set.
- Arbiter: each cycle the lowest-index set `pend[i]` is pushed to the FIFO as {i, `pend_ts[i]`}, and its `pend[i]` is cleared. At most one push per cycle.
  - A push is allowed when the FIFO is not full, or when it is full and a pop happens in the same cycle.
  - If no push is allowed, pending bits hold.
  - A rise on channel i in the same cycle its pending bit is pushed re-sets `pend[i]` with the new ts. No overflow in that case.
- FIFO: show-ahead, meaning the head record is presented on `evt_*` whenever `evt_valid` = 1. `evt_*` hold stable while `evt_valid & ~evt_ready`.
- Clear: `clear` zeroes all counts and `overflow`. It has priority over a same-cycle rise, so the count is 0 afterwards. The rise is still pended and queued. The FIFO, pending bits and `ts` are unaffected.
- `any_error` = `|s1`.

## Timing
- Reset values:
  - `evt_valid`=0, `evt_channel`=0, `evt_timestamp`=0, `count`=0, `overflow`=0, `any_error`=0;
  - `s1`=`s2`=0, `pend`=0, FIFO empty, `ts`=0.
- Latency for a `sensor_error` rise seen at edge k (s1=1):
  - `rise` is high in cycle k→k+1;
  - `count` increments and `pend` is set at edge k+1;
  - the FIFO push happens at edge k+2;
  - `evt_valid`=1 after edge k+2.
- Throughput: one event per cycle sustained when `evt_ready`=1.
- Reset mid-operation: all queued and pending events are discarded. A `sensor_error` line held high through reset produces a fresh rise 1 cycle after `rst` falls.
- A level held high produces exactly one event. A new event needs the line to fall and rise again, with a low of at least 1 cycle.

## Test plan
- Single upset on ch2 at `ts`=10 → after 2 cycles `evt_valid`=1 with `evt_channel`=2, `evt_timestamp`=10; `count[2]`=1; `overflow`=0.
- Ch0 and ch3 rise in the same cycle with `evt_ready`=1 → records ch0 then ch3 on consecutive cycles, both carrying the same timestamp; counts are 1 and 1.
- `evt_ready`=0, then 10 distinct single-channel upsets with `FIFO_DEPTH`=8 → `evt_valid` stays 1, the FIFO holds 8 records, and the remaining upsets stay pending.
  - Ch1 pulses twice while its event is still pending → `count[1]` reflects both pulses, only the first pulse's timestamp is queued, and `overflow`=1.
  - Then raise `evt_ready` → records drain in order and no record is duplicated.
- With `COUNT_W`=4, 20 pulses on ch0 → `count[0]` stops at 15.
  - `clear` issued in the same cycle as a rise → `count[0]`=0 and `overflow`=0, and that event is still emitted.
- Hold `sensor_error[1]`=1 across `rst` → after reset exactly one ch1 event with timestamp 1.
  - Preload `ts` near wrap (run 2^TS_W−2 cycles at TS_W=8) → the record timestamp shows the wrapped value and no other state is disturbed.
